// File: rtl/axi_rd_arbiter.sv
// Read-channel arbiter sharing one AXI AR/R port between I and D requesters.
// Optional round-robin arbitration is enabled by defining ARB_RR_EN.
module axi_rd_arbiter #(
  parameter logic [2:0]  ARSIZE = 3'b010,
  parameter int unsigned WCNT_W = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_araddr,
  input  logic [7:0]  i_arlen,
  input  logic        i_arvalid,
  output logic        i_arready,
  output logic        i_rvalid,
  input  logic        i_rready,
  input  logic [31:0] d_araddr,
  input  logic [7:0]  d_arlen,
  input  logic        d_arvalid,
  output logic        d_arready,
  output logic        d_rvalid,
  input  logic        d_rready,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  input  logic        rvalid,
  input  logic        rlast,
  output logic        rready,
  input  logic        awvalid,
  input  logic        awready,
  input  logic        bvalid,
  input  logic        bready
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] AR_I = 3'd1;
  localparam logic [2:0] AR_D = 3'd2;
  localparam logic [2:0] R_I  = 3'd3;
  localparam logic [2:0] R_D  = 3'd4;

  localparam logic [WCNT_W-1:0] WCNT_MAX = '1;

  logic [2:0]        state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              last_grant_q, last_grant_d;  // 1: D was granted last
  logic              d_ok, pick_d, aw_hs, b_hs;

  assign arsize = ARSIZE;
  assign aw_hs  = awvalid & awready;
  assign b_hs   = bvalid & bready;
  assign d_ok   = d_arvalid & (wcnt_q == '0);

`ifdef ARB_RR_EN
  assign pick_d = d_ok & ~(i_arvalid & last_grant_q);
`else
  assign pick_d = d_ok;
`endif

  always_comb begin
    wcnt_d = wcnt_q;
    if (aw_hs && !b_hs && wcnt_q != WCNT_MAX)
      wcnt_d = wcnt_q + WCNT_W'(1);
    else if (b_hs && !aw_hs && wcnt_q != '0)
      wcnt_d = wcnt_q - WCNT_W'(1);
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (pick_d)         state_d = AR_D;
        else if (i_arvalid) state_d = AR_I;
      end
      AR_I: if (i_arvalid && arready) begin
        state_d      = R_I;
        last_grant_d = 1'b0;
      end
      AR_D: if (d_arvalid && arready) begin
        state_d      = R_D;
        last_grant_d = 1'b1;
      end
      R_I: if (rvalid && i_rready && rlast) state_d = IDLE;
      R_D: if (rvalid && d_rready && rlast) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are forced low while rst is high so a mid-burst reset drops the bus at once.
  always_comb begin
    araddr    = '0;
    arlen     = '0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    i_arready = 1'b0;
    d_arready = 1'b0;
    i_rvalid  = 1'b0;
    d_rvalid  = 1'b0;
    if (!rst) begin
      case (state_q)
        AR_I: begin
          araddr    = i_araddr;
          arlen     = i_arlen;
          arvalid   = i_arvalid;
          i_arready = arready;
        end
        AR_D: begin
          araddr    = d_araddr;
          arlen     = d_arlen;
          arvalid   = d_arvalid;
          d_arready = arready;
        end
        R_I: begin
          i_rvalid = rvalid;
          rready   = i_rready;
        end
        R_D: begin
          d_rvalid = rvalid;
          rready   = d_rready;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wcnt_q       <= '0;
      last_grant_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wcnt_q       <= wcnt_d;
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed self-checking bench for axi_rd_arbiter (default or ARB_RR_EN build).
module tb_axi_rd_arbiter;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_AR_I = 3'd1;
  localparam logic [2:0] S_AR_D = 3'd2;
  localparam logic [2:0] S_R_I  = 3'd3;
  localparam logic [2:0] S_R_D  = 3'd4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_araddr, d_araddr, araddr;
  logic [7:0]  i_arlen, d_arlen, arlen;
  logic [2:0]  arsize;
  logic        i_arvalid, i_arready, i_rvalid, i_rready;
  logic        d_arvalid, d_arready, d_rvalid, d_rready;
  logic        arvalid, arready, rvalid, rlast, rready;
  logic        awvalid, awready, bvalid, bready;

  int checks = 0;
  int errors = 0;

  axi_rd_arbiter #(.ARSIZE(3'b010), .WCNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arvalid(i_arvalid), .i_arready(i_arready),
    .i_rvalid(i_rvalid), .i_rready(i_rready),
    .d_araddr(d_araddr), .d_arlen(d_arlen), .d_arvalid(d_arvalid), .d_arready(d_arready),
    .d_rvalid(d_rvalid), .d_rready(d_rready),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rvalid(rvalid), .rlast(rlast), .rready(rready),
    .awvalid(awvalid), .awready(awready), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Entered in AR_x state; completes the address handshake and drops the request.
  task automatic do_ar(input bit is_d, input logic [31:0] a, input logic [7:0] l);
    chk("ar_state", dut.state_q, is_d ? S_AR_D : S_AR_I);
    chk("ar_valid", arvalid, 1'b1);
    chk("ar_addr", araddr, a);
    chk("ar_len", arlen, l);
    arready = 1'b1;
    #1;
    chk("ar_rdy_owner", is_d ? d_arready : i_arready, 1'b1);
    chk("ar_rdy_other", is_d ? i_arready : d_arready, 1'b0);
    cyc(1);
    arready = 1'b0;
    if (is_d) d_arvalid = 1'b0; else i_arvalid = 1'b0;
    #1;
    chk("r_state", dut.state_q, is_d ? S_R_D : S_R_I);
    chk("r_arvalid", arvalid, 1'b0);
  endtask

  task automatic do_r(input bit is_d, input int beats);
    i_rready = 1'b1;
    d_rready = 1'b1;
    for (int k = 0; k < beats; k++) begin
      rvalid = 1'b1;
      rlast  = (k == beats - 1);
      #1;
      chk("beat_owner", is_d ? d_rvalid : i_rvalid, 1'b1);
      chk("beat_other", is_d ? i_rvalid : d_rvalid, 1'b0);
      chk("beat_rready", rready, 1'b1);
      cyc(1);
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
    #1;
    chk("after_last_idle", dut.state_q, S_IDLE);
    chk("after_last_rready", rready, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    i_araddr = '0; i_arlen = '0; i_arvalid = 1'b0; i_rready = 1'b0;
    d_araddr = '0; d_arlen = '0; d_arvalid = 1'b0; d_rready = 1'b0;
    arready = 1'b0; rvalid = 1'b0; rlast = 1'b0;
    awvalid = 1'b0; awready = 1'b0; bvalid = 1'b0; bready = 1'b0;
    cyc(2);
    chk("rst_state", dut.state_q, S_IDLE);
    chk("rst_wcnt", dut.wcnt_q, 0);
    chk("rst_arvalid", arvalid, 1'b0);
    chk("rst_rready", rready, 1'b0);
    chk("rst_arsize", arsize, 3'b010);
    rst = 1'b0;

    // I only, 8-beat burst
    i_araddr = 32'hBFC0_0000; i_arlen = 8'd7; i_arvalid = 1'b1;
    #1;
    chk("i_req_arvalid_lag", arvalid, 1'b0);
    cyc(1);
    chk("i_arready_wait", i_arready, 1'b0);
    do_ar(1'b0, 32'hBFC0_0000, 8'd7);
    do_r(1'b0, 8);

    // Simultaneous contest: last grant is I, so D wins in both builds
    i_araddr = 32'h0000_1000; i_arlen = 8'd0; i_arvalid = 1'b1;
    d_araddr = 32'h0000_2000; d_arlen = 8'd1; d_arvalid = 1'b1;
    cyc(1);
    do_ar(1'b1, 32'h0000_2000, 8'd1);
    d_araddr = 32'h0000_3000; d_arlen = 8'd0; d_arvalid = 1'b1;
    d_rready = 1'b1; rvalid = 1'b1; rlast = 1'b0;
    #1;
    chk("d_beat0", d_rvalid, 1'b1);
    chk("d_beat0_i", i_rvalid, 1'b0);
    cyc(1);
    rlast = 1'b1; d_rready = 1'b0;
    #1;
    chk("d_stall_rready", rready, 1'b0);
    cyc(1);
    chk("d_stall_hold", dut.state_q, S_R_D);
    d_rready = 1'b1;
    cyc(1);
    rvalid = 1'b0; rlast = 1'b0;
    #1;
    chk("gap_idle", dut.state_q, S_IDLE);
    cyc(1);
`ifdef ARB_RR_EN
    do_ar(1'b0, 32'h0000_1000, 8'd0);
    do_r(1'b0, 1);
    cyc(1);
    do_ar(1'b1, 32'h0000_3000, 8'd0);
    do_r(1'b1, 1);
`else
    do_ar(1'b1, 32'h0000_3000, 8'd0);
    do_r(1'b1, 1);
    cyc(1);
    do_ar(1'b0, 32'h0000_1000, 8'd0);
    do_r(1'b0, 1);
`endif

    // Outstanding write blocks D but not I
    awvalid = 1'b1; awready = 1'b1;
    cyc(1);
    awvalid = 1'b0; awready = 1'b0;
    chk("haz_wcnt1", dut.wcnt_q, 1);
    d_araddr = 32'h0000_4000; d_arlen = 8'd0; d_arvalid = 1'b1;
    cyc(2);
    chk("haz_d_blocked", dut.state_q, S_IDLE);
    chk("haz_arvalid", arvalid, 1'b0);
    chk("haz_d_arready", d_arready, 1'b0);
    i_araddr = 32'h0000_5000; i_arlen = 8'd0; i_arvalid = 1'b1;
    cyc(1);
    do_ar(1'b0, 32'h0000_5000, 8'd0);
    do_r(1'b0, 1);
    cyc(1);
    chk("haz_still_blocked", dut.state_q, S_IDLE);
    bvalid = 1'b1; bready = 1'b1;
    cyc(1);
    bvalid = 1'b0; bready = 1'b0;
    chk("haz_b_wcnt0", dut.wcnt_q, 0);
    chk("haz_b_idle", dut.state_q, S_IDLE);
    cyc(1);
    do_ar(1'b1, 32'h0000_4000, 8'd0);
    do_r(1'b1, 1);

    // Counter corner cases
    bvalid = 1'b1; bready = 1'b1;
    cyc(1);
    chk("wcnt_floor", dut.wcnt_q, 0);
    bvalid = 1'b0;
    awvalid = 1'b1; awready = 1'b1;
    cyc(1);
    bvalid = 1'b1;
    cyc(1);
    chk("wcnt_aw_b_same", dut.wcnt_q, 1);
    bvalid = 1'b0;
    cyc(1);
    chk("wcnt_two", dut.wcnt_q, 2);
    cyc(6);
    chk("wcnt_sat", dut.wcnt_q, 7);
    awvalid = 1'b0; awready = 1'b0;
    bvalid = 1'b1;
    cyc(6);
    chk("wcnt_dec6", dut.wcnt_q, 1);
    cyc(1);
    chk("wcnt_dec7", dut.wcnt_q, 0);
    bvalid = 1'b0; bready = 1'b0;

    // Reset during beat 3 of a D burst
    d_araddr = 32'h0000_6000; d_arlen = 8'd3; d_arvalid = 1'b1;
    cyc(1);
    do_ar(1'b1, 32'h0000_6000, 8'd3);
    d_rready = 1'b1; rvalid = 1'b1;
    awvalid = 1'b1; awready = 1'b1;
    cyc(1);
    awvalid = 1'b0; awready = 1'b0;
    chk("pre_rst_wcnt", dut.wcnt_q, 1);
    cyc(1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    #1;
    chk("mid_rst_state", dut.state_q, S_IDLE);
    chk("mid_rst_wcnt", dut.wcnt_q, 0);
    chk("mid_rst_arvalid", arvalid, 1'b0);
    chk("mid_rst_rready", rready, 1'b0);
    chk("mid_rst_d_rvalid", d_rvalid, 1'b0);
    rvalid = 1'b0;
    cyc(2);
    chk("post_rst_idle", dut.state_q, S_IDLE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
